cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Coprocessor-0 exception/interrupt controller in the MEM stage of the pipelined MIPS core.
- Consumes the exception codes and victim PC flowing down the pipe, plus the 6 hardware interrupt lines.
- Decides whether to take an interrupt or exception and raises int_exc to the fetch-stage PC and the pipeline flush logic.
- Holds SR, Cause, EPC and PRId; supplies epc_out for eret and serves mfc0/mtc0.

Parameters:
- PRID_VAL, 32'h0000_0721, constant value returned on reads of PRId (reg 15).
- HANDLER_PC, 32'h0000_4180, exception vector; exported for fetch use only, never stored here.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- we  input  1  mtc0 write enable (MEM stage)
- rd_addr  input  5  mfc0 source register number
- wr_addr  input  5  mtc0 destination register number
- din  input  32  mtc0 write data
- pc_m  input  32  PC of the instruction in MEM
- bd_m  input  1  MEM instruction sits in a branch delay slot
- exc_code_m  input  5  pending exception code of the MEM instruction; 0 = none
- eret_m  input  1  eret in MEM
- hw_int  input  6  hardware interrupt requests, level-sensitive
- int_exc  output  1  take interrupt/exception this cycle
- epc_out  output  32  current EPC register value
- dout  output  32  mfc0 read data (combinational)

Behaviour:
- Registers and field layout:
  - SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC: 32 bits.
  - PRId: constant PRID_VAL.
- Reset: SR, Cause and EPC all clear to 0. int_exc is forced to 0 while reset is high. dout and epc_out reflect the cleared registers.
- Request terms (combinational):
  - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc_req = (exc_code_m != 0) & ~SR.EXL
  - int_exc = (int_req | exc_req) & ~reset
  - int_exc is valid in the same cycle as its inputs (zero latency).
- Priority: an interrupt beats a synchronous exception in the same cycle.
- Cause.IP <= hw_int on every clock edge, unconditionally, including cycles with int_exc or EXL set.
- On a posedge with int_exc=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exc_code_m.
  - Cause.BD <= bd_m.
  - EPC <= bd_m ? pc_m - 4 : pc_m. The subtraction is mod 2^32. Misaligned values are stored unchanged so that AdEL reports the bad PC.
  - Any mtc0 in the same cycle is discarded.
- On a posedge with eret_m=1 and int_exc=0: SR.EXL <= 0.
  - eret only executes with EXL=1, which blocks int_exc, so eret and int_exc are mutually exclusive in practice.
  - If both are ever high, int_exc wins and EXL stays 1.
- mtc0 (we=1, int_exc=0) updates on the posedge:
  - wr_addr 12: SR.IM <= din[15:10], SR.EXL <= din[1], SR.IE <= din[0].
  - wr_addr 14: EPC <= din (full 32 bits).
  - wr_addr 13, 15 and any other address: ignored.
- mtc0 and eret in the same cycle: both take effect. eret's EXL clear overrides an SR write of EXL.
- mfc0: dout is a combinational mux on rd_addr.
  - 12: SR image. 13: Cause image. 14: EPC. 15: PRID_VAL. Any other address: 0.
  - No write-to-read bypass; hazard logic stalls.
- epc_out is the EPC register value (no bypass). An mtc0 to EPC becomes visible one cycle later.
- Nested events: while EXL=1, all exceptions and interrupts are masked and leave EPC and Cause.ExcCode unchanged.

Decomposition:
- Shared package cp0_pkg:
  - Register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - Field bit positions for IM, IP, EXL, IE, BD and ExcCode.
- One natural sub-module, cp0_exc_arbiter: purely combinational, produces int_req, exc_req, int_exc and the selected ExcCode. The register file stays in cp0_unit.

Test Plan:
- Reset, then mfc0 rd_addr=12/13/14/15 -> dout = 0, 0, 0, 32'h0000_0721; int_exc=0 even with exc_code_m=4 during reset.
- mtc0 SR din=32'h0000_0401 (IM[10]=1, IE=1), then hw_int=6'b000001 with pc_m=32'h0000_3010 -> int_exc=1 the same cycle. Next cycle: EPC=32'h0000_3010, Cause.ExcCode=0, SR.EXL=1, int_exc=0.
- exc_code_m=12 (Ov) with bd_m=1, pc_m=32'h0000_3024, SR=0 -> int_exc=1. Then EPC=32'h0000_3020, Cause=32'h8000_0030.
- Interrupt and exc_code_m=4 in the same cycle with IE/IM enabled -> ExcCode=0. EPC=pc_m.
- With EXL=1, apply exc_code_m=5 -> int_exc=0 and EPC unchanged. Then eret_m=1 -> EXL=0 next cycle, epc_out holds the earlier value.
- mtc0 EPC din=32'h0000_3100 in the same cycle as exc_code_m=10 -> write discarded; EPC=pc_m, ExcCode=10.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and helpers that build the architectural SR/Cause images.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int EXC_HI  = 6;
  localparam int EXC_LO  = 2;

  function automatic logic [31:0] sr_image(input logic [5:0] im, input logic exl,
                                           input logic ie);
    logic [31:0] img;
    img                = 32'd0;
    img[IM_HI:IM_LO]   = im;
    img[EXL_BIT]       = exl;
    img[IE_BIT]        = ie;
    return img;
  endfunction

  function automatic logic [31:0] cause_image(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] exc);
    logic [31:0] img;
    img                = 32'd0;
    img[BD_BIT]        = bd;
    img[IP_HI:IP_LO]   = ip;
    img[EXC_HI:EXC_LO] = exc;
    return img;
  endfunction

endpackage

// File: rtl/cp0_unit_exc_arbiter.sv
// Combinational exception/interrupt arbiter: decides whether the MEM-stage
// event is taken and which ExcCode gets recorded.
module cp0_exc_arbiter
  import cp0_pkg::*;
(
  input  logic       reset_i,
  input  logic [5:0] hw_int_i,
  input  logic [5:0] sr_im_i,
  input  logic       sr_ie_i,
  input  logic       sr_exl_i,
  input  logic [4:0] exc_code_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic       int_exc_o,
  output logic [4:0] exc_code_o
);

  assign int_req_o  = (|(hw_int_i & sr_im_i)) & sr_ie_i & ~sr_exl_i;
  assign exc_req_o  = (exc_code_i != EXC_INT) & ~sr_exl_i;
  assign int_exc_o  = (int_req_o | exc_req_o) & ~reset_i;
  // Asynchronous interrupts take priority over the synchronous exception.
  assign exc_code_o = int_req_o ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 in the MEM stage: SR/Cause/EPC/PRId register file, exception
// entry, eret return and the mfc0/mtc0 access path.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h0000_0721,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] din,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  output logic        int_exc,
  output logic [31:0] epc_out,
  output logic [31:0] dout
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [4:0]  exc_code_sel;

  cp0_exc_arbiter u_arb (
    .reset_i    (reset),
    .hw_int_i   (hw_int),
    .sr_im_i    (sr_im_q),
    .sr_ie_i    (sr_ie_q),
    .sr_exl_i   (sr_exl_q),
    .exc_code_i (exc_code_m),
    .int_req_o  (int_req),
    .exc_req_o  (exc_req),
    .int_exc_o  (int_exc),
    .exc_code_o (exc_code_sel)
  );

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (int_exc) begin
      // Exception entry squashes any mtc0 or eret issued in the same cycle.
      sr_exl_d    = 1'b1;
      cause_exc_d = exc_code_sel;
      cause_bd_d  = bd_m;
      epc_d       = bd_m ? (pc_m - 32'd4) : pc_m;
    end else begin
      if (we) begin
        case (wr_addr)
          CP0_SR: begin
            sr_im_d  = din[IM_HI:IM_LO];
            sr_exl_d = din[EXL_BIT];
            sr_ie_d  = din[IE_BIT];
          end
          CP0_EPC: epc_d = din;
          default: ;
        endcase
      end
      if (eret_m) sr_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  assign epc_out = epc_q;

  // No write-to-read forwarding: the hazard unit stalls mfc0 behind mtc0.
  always_comb begin
    dout = 32'd0;
    case (rd_addr)
      CP0_SR:    dout = sr_image(sr_im_q, sr_exl_q, sr_ie_q);
      CP0_CAUSE: dout = cause_image(cause_bd_q, cause_ip_q, cause_exc_q);
      CP0_EPC:   dout = epc_q;
      CP0_PRID:  dout = PRID_VAL;
      default:   dout = 32'd0;
    endcase
  end

endmodule
